// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, its RAM port and the downstream controller.
// The master modport is the fetch unit; the slave modport is the RAM/controller side.
interface fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] start_pc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              ir_ready;
  logic              done;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_new;
  logic              dreq;
  logic              dwe;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dwdata;
  logic [DATA_W-1:0] drdata;
  logic              dack;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  modport master (
    input  start_pc, mem_rdata, ir_ready, done, pc_load, pc_new,
           dreq, dwe, daddr, dwdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata, ir, ir_valid,
           drdata, dack, pc, halted
  );

  modport slave (
    output start_pc, mem_rdata, ir_ready, done, pc_load, pc_new,
           dreq, dwe, daddr, dwdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, ir, ir_valid,
           drdata, dack, pc, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from a single-port synchronous RAM,
// hands instructions to the controller and multiplexes its LDR/STR accesses onto the port.
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_EXEC  = 3'd3,
    S_DACC  = 3'd4,
    S_DWAIT = 3'd5,
    S_HALT  = 3'd6
  } state_e;

  localparam logic [2:0] HALT_OP = 3'b111;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              dack_q, dack_d;
  logic              halted_q, halted_d;
  logic              dwe_q, dwe_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] dwdata_q, dwdata_d;

  logic [ADDR_W-1:0] mem_addr_s;
  logic              mem_rd_s;
  logic              mem_wr_s;

  // State and datapath registers; the PC reloads asynchronously from start_pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= bus.start_pc;
      ir_q       <= {DATA_W{1'b0}};
      ir_valid_q <= 1'b0;
      drdata_q   <= {DATA_W{1'b0}};
      dack_q     <= 1'b0;
      halted_q   <= 1'b0;
      dwe_q      <= 1'b0;
      daddr_q    <= {ADDR_W{1'b0}};
      dwdata_q   <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      drdata_q   <= drdata_d;
      dack_q     <= dack_d;
      halted_q   <= halted_d;
      dwe_q      <= dwe_d;
      daddr_q    <= daddr_d;
      dwdata_q   <= dwdata_d;
    end
  end

  // Next-state logic; dack is a pulse so it defaults low every cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    drdata_d   = drdata_q;
    dack_d     = 1'b0;
    halted_d   = halted_q;
    dwe_d      = dwe_q;
    daddr_d    = daddr_q;
    dwdata_d   = dwdata_q;
    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        ir_d       = bus.mem_rdata;
        pc_d       = pc_q + ADDR_W'(1);
        ir_valid_d = 1'b1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (bus.ir_ready) begin
          ir_valid_d = 1'b0;
          if (ir_q[DATA_W-1 -: 3] == HALT_OP) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            state_d  = S_EXEC;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      S_EXEC: begin
        // A data request wins over a simultaneous done; the controller re-pulses done.
        if (bus.dreq) begin
          dwe_d    = bus.dwe;
          daddr_d  = bus.daddr;
          dwdata_d = bus.dwdata;
          state_d  = S_DACC;
        end else if (bus.done) begin
          pc_d    = bus.pc_load ? bus.pc_new : pc_q;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_DACC: state_d = S_DWAIT;
      S_DWAIT: begin
        drdata_d = dwe_q ? drdata_q : bus.mem_rdata;
        dack_d   = 1'b1;
        state_d  = S_EXEC;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // RAM port decode, combinational from state so strobes drop as soon as reset hits.
  always_comb begin
    mem_addr_s = pc_q;
    mem_rd_s   = 1'b0;
    mem_wr_s   = 1'b0;
    case (state_q)
      S_FETCH: mem_rd_s = 1'b1;
      S_DACC: begin
        mem_addr_s = daddr_q;
        mem_rd_s   = ~dwe_q;
        mem_wr_s   = dwe_q;
      end
      default: mem_addr_s = pc_q;
    endcase
  end

  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_rd    = mem_rd_s;
  assign bus.mem_wr    = mem_wr_s;
  assign bus.mem_wdata = dwdata_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.drdata    = drdata_q;
  assign bus.dack      = dack_q;
  assign bus.pc        = pc_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural synchronous RAM plus per-scenario tasks.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  fetch_unit #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic        load_en = 1'b0;
  logic [7:0]  load_addr = 8'h00;
  logic [15:0] load_data = 16'h0000;
  logic [15:0] mem [0:255];

  // Synchronous single-port RAM with a bench-side preload port.
  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic idle_inputs();
    bus.ir_ready = 1'b0;
    bus.done     = 1'b0;
    bus.pc_load  = 1'b0;
    bus.pc_new   = 8'h00;
    bus.dreq     = 1'b0;
    bus.dwe      = 1'b0;
    bus.daddr    = 8'h00;
    bus.dwdata   = 16'h0000;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic accept();
    bus.ir_ready = 1'b1;
    @(negedge clk);
    bus.ir_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_pc = 8'h01;
    idle_inputs();
    bus.mem_rdata = 16'h0000;
    preload(8'h01, 16'hA101);
    preload(8'h02, 16'h1202);
    preload(8'h10, 16'h0002);
    preload(8'h40, 16'h4040);
    preload(8'h41, 16'h5041);
    checks++; if (bus.ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got=%h exp=0000", bus.ir); end
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got=%b exp=0", bus.ir_valid); end
    checks++; if (bus.pc !== 8'h01) begin errors++; $display("FAIL reset_pc got=%h exp=01", bus.pc); end
    checks++; if (bus.drdata !== 16'h0000) begin errors++; $display("FAIL reset_drdata got=%h exp=0000", bus.drdata); end
    checks++; if (bus.dack !== 1'b0) begin errors++; $display("FAIL reset_dack got=%b exp=0", bus.dack); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    rst_n = 1'b1;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h01) begin errors++; $display("FAIL cycle0_fetch rd=%b addr=%h exp rd=1 addr=01", bus.mem_rd, bus.mem_addr); end
    @(negedge clk);
    checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL cycle1_wait_rd got=%b exp=0", bus.mem_rd); end
    @(negedge clk);
    checks++; if (bus.ir !== 16'hA101 || bus.ir_valid !== 1'b1 || bus.pc !== 8'h02) begin
      errors++; $display("FAIL cycle2_hold ir=%h v=%b pc=%h exp ir=A101 v=1 pc=02", bus.ir, bus.ir_valid, bus.pc);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.ir_valid !== 1'b1 || bus.ir !== 16'hA101 || bus.mem_rd !== 1'b0) begin
        errors++; $display("FAIL hold_stall ir=%h v=%b rd=%b exp ir=A101 v=1 rd=0", bus.ir, bus.ir_valid, bus.mem_rd);
      end
    end
  endtask

  task automatic test_accept_done();
    accept();
    checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL accept_clears_valid got=%b exp=0", bus.ir_valid); end
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h02) begin errors++; $display("FAIL seq_fetch rd=%b addr=%h exp rd=1 addr=02", bus.mem_rd, bus.mem_addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.ir !== 16'h1202 || bus.ir_valid !== 1'b1 || bus.pc !== 8'h03) begin
      errors++; $display("FAIL seq_hold ir=%h v=%b pc=%h exp ir=1202 v=1 pc=03", bus.ir, bus.ir_valid, bus.pc);
    end
    accept();
    bus.done    = 1'b1;
    bus.pc_load = 1'b1;
    bus.pc_new  = 8'h40;
    @(negedge clk);
    bus.done    = 1'b0;
    bus.pc_load = 1'b0;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h40) begin errors++; $display("FAIL branch_fetch rd=%b addr=%h exp rd=1 addr=40", bus.mem_rd, bus.mem_addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.pc !== 8'h41 || bus.ir !== 16'h4040 || bus.ir_valid !== 1'b1) begin
      errors++; $display("FAIL branch_hold pc=%h ir=%h v=%b exp pc=41 ir=4040 v=1", bus.pc, bus.ir, bus.ir_valid);
    end
    accept();
  endtask

  task automatic test_data_read();
    bus.dreq  = 1'b1;
    bus.dwe   = 1'b0;
    bus.daddr = 8'h10;
    @(negedge clk);
    bus.dreq  = 1'b0;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_addr !== 8'h10) begin
      errors++; $display("FAIL read_dacc rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=10", bus.mem_rd, bus.mem_wr, bus.mem_addr);
    end
    @(negedge clk);
    checks++; if (bus.dack !== 1'b0) begin errors++; $display("FAIL read_dwait_dack got=%b exp=0", bus.dack); end
    @(negedge clk);
    checks++; if (bus.dack !== 1'b1 || bus.drdata !== 16'h0002) begin
      errors++; $display("FAIL read_dack dack=%b drdata=%h exp dack=1 drdata=0002", bus.dack, bus.drdata);
    end
  endtask

  task automatic test_back_to_back();
    bus.dreq   = 1'b1;
    bus.dwe    = 1'b1;
    bus.daddr  = 8'h20;
    bus.dwdata = 16'hBEEF;
    @(negedge clk);
    bus.dreq   = 1'b0;
    bus.dwe    = 1'b0;
    checks++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 8'h20 || bus.mem_wdata !== 16'hBEEF) begin
      errors++; $display("FAIL write_dacc wr=%b rd=%b addr=%h wdata=%h exp wr=1 rd=0 addr=20 wdata=BEEF", bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    checks++; if (bus.dack !== 1'b0) begin errors++; $display("FAIL write_dwait_dack got=%b exp=0", bus.dack); end
    @(negedge clk);
    checks++; if (bus.dack !== 1'b1 || bus.drdata !== 16'h0002) begin
      errors++; $display("FAIL write_dack dack=%b drdata=%h exp dack=1 drdata=0002", bus.dack, bus.drdata);
    end
    checks++; if (mem[8'h20] !== 16'hBEEF) begin errors++; $display("FAIL write_mem got=%h exp=BEEF", mem[8'h20]); end
    @(negedge clk);
    checks++; if (bus.dack !== 1'b0) begin errors++; $display("FAIL dack_pulse got=%b exp=0", bus.dack); end
  endtask

  task automatic test_dreq_done();
    int strobes;
    bus.dreq  = 1'b1;
    bus.dwe   = 1'b0;
    bus.daddr = 8'h10;
    bus.done  = 1'b1;
    @(negedge clk);
    bus.dreq  = 1'b0;
    bus.done  = 1'b0;
    checks++; if (bus.mem_addr !== 8'h10 || bus.mem_rd !== 1'b1) begin
      errors++; $display("FAIL collide_dacc addr=%h rd=%b exp addr=10 rd=1", bus.mem_addr, bus.mem_rd);
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.dack !== 1'b1) begin errors++; $display("FAIL collide_dack got=%b exp=1", bus.dack); end
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1) strobes++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL collide_no_fetch strobes=%0d exp=0", strobes); end
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h41) begin
      errors++; $display("FAIL redone_fetch rd=%b addr=%h exp rd=1 addr=41", bus.mem_rd, bus.mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.ir !== 16'h5041 || bus.ir_valid !== 1'b1 || bus.pc !== 8'h42) begin
      errors++; $display("FAIL redone_hold ir=%h v=%b pc=%h exp ir=5041 v=1 pc=42", bus.ir, bus.ir_valid, bus.pc);
    end
  endtask

  task automatic test_wrap_halt();
    int strobes;
    rst_n = 1'b0;
    bus.start_pc = 8'hFF;
    idle_inputs();
    preload(8'hFF, 16'hE000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.pc !== 8'h00 || bus.ir !== 16'hE000 || bus.ir_valid !== 1'b1 || bus.halted !== 1'b0) begin
      errors++; $display("FAIL wrap_hold pc=%h ir=%h v=%b h=%b exp pc=00 ir=E000 v=1 h=0", bus.pc, bus.ir, bus.ir_valid, bus.halted);
    end
    accept();
    checks++; if (bus.halted !== 1'b1 || bus.ir_valid !== 1'b0) begin
      errors++; $display("FAIL halt_entry h=%b v=%b exp h=1 v=0", bus.halted, bus.ir_valid);
    end
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      bus.done     = i[0];
      bus.dreq     = ~i[0];
      bus.dwe      = 1'b1;
      bus.ir_ready = 1'b1;
      @(negedge clk);
      if (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1) strobes++;
    end
    idle_inputs();
    checks++; if (strobes !== 0) begin errors++; $display("FAIL halt_quiet strobes=%0d exp=0", strobes); end
    checks++; if (bus.halted !== 1'b1 || bus.ir !== 16'hE000 || bus.dack !== 1'b0) begin
      errors++; $display("FAIL halt_hold h=%b ir=%h dack=%b exp h=1 ir=E000 dack=0", bus.halted, bus.ir, bus.dack);
    end
  endtask

  task automatic test_reset_mid_access();
    rst_n = 1'b0;
    bus.start_pc = 8'h01;
    idle_inputs();
    preload(8'h30, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    accept();
    bus.dreq   = 1'b1;
    bus.dwe    = 1'b1;
    bus.daddr  = 8'h30;
    bus.dwdata = 16'h1234;
    @(negedge clk);
    bus.dreq   = 1'b0;
    bus.dwe    = 1'b0;
    checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL midrst_pre_wr got=%b exp=1", bus.mem_wr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL midrst_wr_drop got=%b exp=0", bus.mem_wr); end
    checks++; if (bus.ir_valid !== 1'b0 || bus.pc !== 8'h01 || bus.dack !== 1'b0 || bus.halted !== 1'b0) begin
      errors++; $display("FAIL midrst_state v=%b pc=%h dack=%b h=%b exp v=0 pc=01 dack=0 h=0", bus.ir_valid, bus.pc, bus.dack, bus.halted);
    end
    @(negedge clk);
    checks++; if (mem[8'h30] !== 16'h0000) begin errors++; $display("FAIL midrst_no_write got=%h exp=0000", mem[8'h30]); end
    rst_n = 1'b1;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h01) begin
      errors++; $display("FAIL midrst_restart rd=%b addr=%h exp rd=1 addr=01", bus.mem_rd, bus.mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.ir_valid !== 1'b1 || bus.ir !== 16'hA101 || bus.pc !== 8'h02) begin
      errors++; $display("FAIL midrst_refetch v=%b ir=%h pc=%h exp v=1 ir=A101 pc=02", bus.ir_valid, bus.ir, bus.pc);
    end
  endtask

  initial begin
    test_reset();
    test_accept_done();
    test_data_read();
    test_back_to_back();
    test_dreq_done();
    test_wrap_halt();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and memory-port stage that sits directly upstream of the `task2` datapath/controller. It owns the program counter, fetches 16-bit instructions from a single-port synchronous RAM, and presents them to the controller with a valid/ready handshake. It also arbitrates the controller's LDR/STR data accesses onto the same RAM port, and latches HALT.

## Interface
- `ADDR_W`, default 8, memory/PC address width
- `DATA_W`, default 16, instruction/data word width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock; asynchronous, active-low
- `start_pc`  in  ADDR_W  PC load value; must be stable while `rst_n`=0
- `mem_addr`  out  ADDR_W  RAM address; combinational from state
- `mem_rd`  out  1  RAM read strobe; data returns on `mem_rdata` in the following cycle
- `mem_wr`  out  1  RAM write strobe
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data
- `ir`  out  DATA_W  instruction register
- `ir_valid`  out  1  `ir` holds a fresh instruction
- `ir_ready`  in  1  controller accepts `ir`
- `done`  in  1  one-cycle pulse: current instruction finished
- `pc_load`  in  1  with `done`: next PC = `pc_new`
- `pc_new`  in  ADDR_W  branch target
- `dreq`  in  1  one-cycle data-access request
- `dwe`  in  1  with `dreq`: 1 = write, 0 = read
- `daddr`  in  ADDR_W  data address, sampled with `dreq`
- `dwdata`  in  DATA_W  write data, sampled with `dreq`
- `drdata`  out  DATA_W  read data, held until the next read completes
- `dack`  out  1  one-cycle access-complete pulse
- `pc`  out  ADDR_W  current PC (debug)
- `halted`  out  1  HALT fetched and accepted

## Operation
- States: FETCH, WAIT, HOLD, EXEC, DACC, DWAIT, HALT.
- Reset (asynchronous, any state) sets:
  - state=FETCH, `pc`=`start_pc`
  - `ir`=0, `ir_valid`=0, `drdata`=0, `dack`=0, `halted`=0
  - data latches = 0
- FETCH: `mem_addr`=`pc`, `mem_rd`=1. Next state: WAIT.
- WAIT: `mem_rd`=0; `mem_rdata` is valid. At the edge: `ir`←`mem_rdata`, `pc`←`pc`+1 (modulo 2^ADDR_W, 255→0), `ir_valid`←1. Next state: HOLD.
- HOLD: `ir_valid`=1, `ir` stable.
  - `ir_ready`=1: `ir_valid`←0. If `ir[15:13]`=3'b111, go to HALT (`halted`←1); otherwise go to EXEC.
  - `ir_ready`=0: stay in HOLD.
- EXEC: `ir` stable, `ir_valid`=0.
  - `dreq`=1: latch `dwe`/`daddr`/`dwdata`, go to DACC.
  - `done`=1 (no `dreq`): if `pc_load`=1, `pc`←`pc_new`; go to FETCH.
  - `dreq` and `done` in the same cycle: `dreq` wins and `done` is dropped; the controller must re-pulse `done`.
- DACC: `mem_addr`=latched `daddr`; `mem_rd`=!`dwe`, `mem_wr`=`dwe`, `mem_wdata`=latched `dwdata`. Next state: DWAIT.
- DWAIT: for a read, `drdata`←`mem_rdata` at the edge. `dack`←1 at the edge. Next state: EXEC.
- `dack` is high for exactly the first EXEC cycle after DWAIT. `drdata` is valid in that cycle.
- `dreq`, `done` and `ir_ready` are ignored outside EXEC/HOLD respectively.
- HALT: no memory strobes, `halted`=1, `ir` holds the HALT word. Only reset exits HALT.
- Idle outputs: `mem_addr`=`pc`, `mem_rd`=`mem_wr`=0, `mem_wdata`=latched `dwdata`.

## Timing
- Cycle 0 is the first cycle after `rst_n` rises:
  - cycle 0 = FETCH
  - cycle 1 = WAIT
  - cycle 2 = HOLD, `ir_valid`=1, `pc`=`start_pc`+1
- Fetch latency: 2 cycles from FETCH to `ir_valid`.
- Accept-to-refetch: minimum 1 EXEC cycle. `done` sampled in cycle c puts FETCH in c+1 and `ir_valid` in c+3.
- Data access: `dreq` sampled in cycle c → DACC in c+1 → DWAIT in c+2 → `dack`=1 in c+3.
- Back-to-back accesses: `dreq` may be pulsed again in the `dack` cycle.
- Reset mid-access: `mem_rd`/`mem_wr` drop immediately (combinational from state). Any in-flight `dack`/`ir_valid` is cancelled.

## Test plan
- Reset release, `start_pc`=1, mem[1]=16'hA101 → `mem_rd` with `mem_addr`=1 in cycle 0; `ir`=16'hA101, `ir_valid`=1, `pc`=2 in cycle 2; `ir_valid` stays high while `ir_ready`=0.
- Accept, then `done` with `pc_load`=0 → next fetch from address 2. `done` with `pc_load`=1, `pc_new`=8'h40 → fetch from 8'h40, `pc`=8'h41 after WAIT.
- Read: `dreq`, `dwe`=0, `daddr`=8'h10, mem[8'h10]=16'h0002 → `mem_rd`/`mem_addr`=8'h10 at c+1; `dack`=1, `drdata`=16'h0002 at c+3. Write: `dwe`=1, `dwdata`=16'hBEEF, `daddr`=8'h20 → `mem_wr`=1 at c+1, `dack` at c+3, mem[8'h20]=16'hBEEF.
- `dreq` and `done` in the same cycle → data access served, no fetch; fetch starts only after `done` is re-pulsed.
- `start_pc`=8'hFF → `pc`=8'h00 after first fetch. mem[8'hFF]=16'hE000 accepted → `halted`=1; no further `mem_rd` over 20 cycles.
- `rst_n` asserted during DACC (write) → `mem_wr`=0 immediately; after release, `ir_valid`=0, `pc`=`start_pc`, fetch restarts in cycle 0.
